// File: rtl/arm_dmem_io.sv
// Data-memory responder for the ARM core: word RAM plus a memory-mapped
// I/O page (LED register, synchronized switches, compare timer with IRQ).
module arm_dmem_io #(
  parameter int unsigned RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_TCTRL,
    SEL_TSTAT
  } sel_t;

  sel_t        sel;
  logic [31:0] mem [RAM_WORDS];
  logic [7:0]  sw_s1;
  logic [7:0]  sw_s2;
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic [2:0]  tctrl;   // [0] EN, [1] AUTORELOAD, [2] IRQEN
  logic        match;
  logic        hit;
  logic [31:0] tcount_nx;
  logic        match_nx;
  logic        wr;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^ALUResult[1:0];
  assign wr = MemWrite;

  // Address decode: RAM window at the bottom, I/O page at 0xFFFF_FF00.
  always_comb begin
    sel = SEL_NONE;
    if (ALUResult[31:AW+2] == '0) begin
      sel = SEL_RAM;
    end else if (ALUResult[31:8] == 24'hFF_FFFF) begin
      case (ALUResult[7:2])
        6'd0:    sel = SEL_LED;
        6'd1:    sel = SEL_SW;
        6'd2:    sel = SEL_TCOUNT;
        6'd3:    sel = SEL_TCMP;
        6'd4:    sel = SEL_TCTRL;
        6'd5:    sel = SEL_TSTAT;
        default: sel = SEL_NONE;
      endcase
    end
  end

  // Asynchronous load path.
  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM:    ReadData = mem[ALUResult[AW+1:2]];
      SEL_LED:    ReadData = {24'h0, led};
      SEL_SW:     ReadData = {24'h0, sw_s2};
      SEL_TCOUNT: ReadData = tcount;
      SEL_TCMP:   ReadData = tcmp;
      SEL_TCTRL:  ReadData = {29'h0, tctrl};
      SEL_TSTAT:  ReadData = {31'h0, match};
      default:    ReadData = '0;
    endcase
  end

  // Timer next state; match uses pre-write values, CPU write to TCOUNT wins
  // over increment/reload, and a match set wins over a W1C clear.
  always_comb begin
    hit       = tctrl[0] && (tcount == tcmp);
    tcount_nx = tcount;
    if (tctrl[0]) begin
      tcount_nx = (hit && tctrl[1]) ? '0 : tcount + 32'd1;
    end
    if (wr && (sel == SEL_TCOUNT)) begin
      tcount_nx = WriteData;
    end
    match_nx = match;
    if (wr && (sel == SEL_TSTAT) && WriteData[0]) begin
      match_nx = 1'b0;
    end
    if (hit) begin
      match_nx = 1'b1;
    end
  end

  // RAM store port; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr && (sel == SEL_RAM)) begin
      mem[ALUResult[AW+1:2]] <= WriteData;
    end
  end

  // I/O registers, switch synchronizer and registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led    <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      tcount <= '0;
      tcmp   <= '1;
      tctrl  <= '0;
      match  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      tcount <= tcount_nx;
      match  <= match_nx;
      irq    <= match & tctrl[2];
      if (wr && (sel == SEL_LED))   led   <= WriteData[7:0];
      if (wr && (sel == SEL_TCMP))  tcmp  <= WriteData;
      if (wr && (sel == SEL_TCTRL)) tctrl <= WriteData[2:0];
    end
  end

endmodule

// File: tb/tb_arm_dmem_io.sv
// Self-checking bench for arm_dmem_io: directed scenarios followed by random
// bus traffic, all checked against a behavioural model of the memory map.
module tb_arm_dmem_io;

  localparam int unsigned RW = 64;
  localparam logic [31:0] A_LED    = 32'hFFFF_FF00;
  localparam logic [31:0] A_SW     = 32'hFFFF_FF04;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_FF08;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_FF0C;
  localparam logic [31:0] A_TCTRL  = 32'hFFFF_FF10;
  localparam logic [31:0] A_TSTAT  = 32'hFFFF_FF14;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] mram [RW];
  bit          mvalid [RW];
  logic [7:0]  m_led, m_s1, m_s2;
  logic [31:0] m_tcount, m_tcmp;
  logic [2:0]  m_tctrl;
  logic        m_match, m_irq;

  arm_dmem_io #(.RAM_WORDS(RW)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .sw(sw), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_led = '0; m_s1 = '0; m_s2 = '0;
    m_tcount = 32'd0; m_tcmp = 32'hFFFF_FFFF;
    m_tctrl = '0; m_match = 1'b0; m_irq = 1'b0;
  endfunction

  function automatic void mread(input logic [31:0] addr, output bit v, output logic [31:0] d);
    int unsigned idx;
    v = 1'b1;
    d = '0;
    if (addr < 32'(RW * 4)) begin
      idx = addr >> 2;
      v = mvalid[idx];
      d = mram[idx];
    end else begin
      case (addr & ~32'd3)
        A_LED:    d = {24'h0, m_led};
        A_SW:     d = {24'h0, m_s2};
        A_TCOUNT: d = m_tcount;
        A_TCMP:   d = m_tcmp;
        A_TCTRL:  d = {29'h0, m_tctrl};
        A_TSTAT:  d = {31'h0, m_match};
        default:  d = '0;
      endcase
    end
  endfunction

  // One clock edge of the memory map's rules.
  function automatic void model_edge(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic [7:0] swv);
    logic [31:0] a;
    logic [31:0] ntc;
    logic        nmatch, fire;
    a = addr & ~32'd3;
    fire = m_tctrl[0] && (m_tcount == m_tcmp);
    ntc = m_tcount;
    if (m_tctrl[0]) ntc = (fire && m_tctrl[1]) ? 32'd0 : m_tcount + 32'd1;
    nmatch = m_match;
    if (we && a == A_TSTAT && wd[0]) nmatch = 1'b0;
    if (fire) nmatch = 1'b1;
    m_irq = m_match && m_tctrl[2];
    if (we) begin
      if (addr < 32'(RW * 4)) begin
        mram[addr >> 2] = wd;
        mvalid[addr >> 2] = 1'b1;
      end
      if (a == A_LED)    m_led = wd[7:0];
      if (a == A_TCOUNT) ntc = wd;
      if (a == A_TCMP)   m_tcmp = wd;
      if (a == A_TCTRL)  m_tctrl = wd[2:0];
    end
    m_tcount = ntc;
    m_match = nmatch;
    m_s2 = m_s1;
    m_s1 = swv;
  endfunction

  // One bus cycle: drive, sample mid-cycle against the model, clock, update model.
  task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input bit xen = 1'b0, input logic [31:0] xexp = '0,
                     input string tag = "");
    bit v;
    logic [31:0] d;
    MemWrite = we; ALUResult = addr; WriteData = wd;
    #1;
    mread(addr, v, d);
    if (v) chk("rdata", ReadData, d);
    chk("led", {24'h0, led}, {24'h0, m_led});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    if (xen) chk(tag, ReadData, xexp);
    @(posedge clk);
    model_edge(we, addr, wd, sw);
    #1;
  endtask

  // Mid-cycle reset pulse; called one time unit after a rising edge.
  task automatic rst_pulse();
    #1 reset = 1'b0;
    model_reset();
    MemWrite = 1'b0; ALUResult = A_TCOUNT;
    #1 chk("rp_tcount", ReadData, 32'd0);
    chk("rp_led", {24'h0, led}, 32'd0);
    chk("rp_irq", {31'h0, irq}, 32'd0);
    ALUResult = A_TCMP;
    #1 chk("rp_tcmp", ReadData, 32'hFFFF_FFFF);
    ALUResult = A_TCTRL;
    #1 chk("rp_tctrl", ReadData, 32'd0);
    ALUResult = A_TSTAT;
    #1 chk("rp_tstat", ReadData, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] addr, wd;
    logic        we;
    int unsigned pick;
    for (int i = 0; i < int'(RW); i++) mvalid[i] = 1'b0;
    reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; sw = '0;
    #3 reset = 1'b0;
    model_reset();
    #1 chk("rst_led", {24'h0, led}, 32'd0);
    chk("rst_irq", {31'h0, irq}, 32'd0);
    #8 reset = 1'b1;

    // reset defaults
    cyc(0, A_TCOUNT, 0, 1, 32'd0, "def_tcount");
    cyc(0, A_TCMP, 0, 1, 32'hFFFF_FFFF, "def_tcmp");
    cyc(0, A_TCTRL, 0, 1, 32'd0, "def_tctrl");
    cyc(0, A_TSTAT, 0, 1, 32'd0, "def_tstat");
    cyc(0, 32'h0000_1000, 0, 1, 32'd0, "def_unmapped");

    // RAM
    cyc(1, 32'h0C, 32'hDEAD_BEEF);
    cyc(1, 32'(RW * 4 - 4), 32'h1234_5678);
    cyc(1, 32'(RW * 4), 32'hCAFE_F00D);
    cyc(0, 32'h0C, 0, 1, 32'hDEAD_BEEF, "ram_lo");
    cyc(0, 32'(RW * 4 - 4), 0, 1, 32'h1234_5678, "ram_top");
    cyc(0, 32'(RW * 4), 0, 1, 32'd0, "ram_oob");
    cyc(0, 32'h0E, 0, 1, 32'hDEAD_BEEF, "ram_bytealias");

    // LED / SW
    cyc(1, A_LED, 32'hFFFF_FFA5);
    cyc(0, A_LED, 0, 1, 32'h0000_00A5, "led_rb");
    chk("led_pin", {24'h0, led}, 32'h0000_00A5);
    cyc(1, A_SW, 32'hFFFF_FFFF);
    sw = 8'h3C;
    cyc(0, A_SW, 0, 1, 32'h0, "sw_e0");
    cyc(0, A_SW, 0, 1, 32'h0, "sw_e1");
    cyc(0, A_SW, 0, 1, 32'h3C, "sw_e2");

    // timer one-shot
    cyc(1, A_TCMP, 32'd5);
    cyc(1, A_TCTRL, 32'h5);
    for (int i = 0; i < 9; i++) cyc(0, A_TCOUNT, 0, 1, 32'(i), "os_count");
    cyc(0, A_TSTAT, 0, 1, 32'd1, "os_match");
    chk("os_irq", {31'h0, irq}, 32'd1);
    cyc(1, A_TSTAT, 32'd1);
    cyc(0, A_TSTAT, 0, 1, 32'd0, "os_w1c");
    chk("os_irq_clr", {31'h0, irq}, 32'd0);

    // timer autoreload and collisions
    cyc(1, A_TCTRL, 32'd0);
    cyc(1, A_TCOUNT, 32'd0);
    cyc(1, A_TCMP, 32'd3);
    cyc(1, A_TSTAT, 32'd1);
    cyc(1, A_TCTRL, 32'h7);
    for (int k = 0; k < 5; k++) cyc(0, A_TCOUNT, 0, 1, 32'(k % 4), "ar_count");
    cyc(1, A_TSTAT, 32'd1, 1, 32'd1, "ar_match");
    cyc(0, A_TSTAT, 0, 1, 32'd0, "ar_cleared");
    cyc(1, A_TSTAT, 32'd1, 1, 32'd0, "ar_pre_hit");
    cyc(0, A_TSTAT, 0, 1, 32'd1, "ar_set_beats_w1c");
    cyc(1, A_TCOUNT, 32'd100);
    cyc(0, A_TCOUNT, 0, 1, 32'd100, "ar_wr_beats_inc");
    cyc(0, A_TCOUNT, 0, 1, 32'd101, "ar_after_wr");

    // wrap
    cyc(1, A_TCTRL, 32'd0);
    cyc(1, A_TSTAT, 32'd1);
    cyc(1, A_TCMP, 32'd0);
    cyc(1, A_TCOUNT, 32'hFFFF_FFFE);
    cyc(1, A_TCTRL, 32'h1);
    cyc(0, A_TCOUNT, 0, 1, 32'hFFFF_FFFE, "wr_fe");
    cyc(0, A_TSTAT, 0, 1, 32'd0, "wr_nomatch");
    cyc(0, A_TCOUNT, 0, 1, 32'd0, "wr_zero");
    cyc(0, A_TSTAT, 0, 1, 32'd1, "wr_match");
    cyc(0, A_TCOUNT, 0, 1, 32'd2, "wr_cont");
    rst_pulse();
    cyc(0, A_TCOUNT, 0, 1, 32'd0, "rp_held0");
    cyc(0, A_TCOUNT, 0, 1, 32'd0, "rp_held1");

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      pick = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      case (pick)
        0, 1, 2: addr = $urandom_range(0, RW * 4 - 1);
        3:       addr = $urandom_range(RW * 4, RW * 4 + 64);
        4:       begin addr = A_TCOUNT | 32'($urandom_range(0, 3)); wd = $urandom_range(0, 12); end
        5:       begin addr = A_TCMP; wd = $urandom_range(0, 12); end
        6:       addr = A_TCTRL;
        7:       addr = A_TSTAT;
        8:       addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 31));
        default: addr = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      cyc(we, addr, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
